// File: rtl/ddrx_cmd_sched.sv
// ddrx_cmd_sched
// Closed-page DDRx command scheduler for nasti_ddrx_mc. It arbitrates between
// one read and one write request stream and inserts periodic auto-refresh.
// Each access goes out as ACT followed by RD/WR with auto-precharge, and the
// configured DRAM timing gaps are enforced between commands.
// Everything runs in the core_clk domain.
//
// Ports
//   core_clk, core_arstn     : clock (rising edge), async active-low reset
//   init_done                : DFI init complete; no commands issue while low
//   rd_valid/rd_ready        : read request handshake (ready is combinational)
//   rd_bank/rd_row/rd_col    : read target
//   wr_valid/wr_ready        : write request handshake (ready is combinational)
//   wr_bank/wr_row/wr_col    : write target
//   dfi_address, dfi_bank    : registered DFI command address / bank
//   dfi_cs_n .. dfi_we_n     : registered DFI command strobes
//   rd_issue, wr_issue       : one-cycle pulse alongside the RD/WR command
//   ref_busy                 : high from the REF command to the end of tRFC
module ddrx_cmd_sched #(
    parameter int C_DFI_ADDR_WIDTH = 14,
    parameter int C_DFI_BANK_WIDTH = 3,
    parameter int C_TRCD           = 4,
    parameter int C_TPOST          = 8,
    parameter int C_TRFC           = 32,
    parameter int C_TREFI          = 3120,
    parameter int C_WR_STARVE      = 8
) (
    input  logic                          core_clk,
    input  logic                          core_arstn,
    input  logic                          init_done,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [C_DFI_BANK_WIDTH-1:0]   rd_bank,
    input  logic [C_DFI_ADDR_WIDTH-1:0]   rd_row,
    input  logic [C_DFI_ADDR_WIDTH-2:0]   rd_col,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [C_DFI_BANK_WIDTH-1:0]   wr_bank,
    input  logic [C_DFI_ADDR_WIDTH-1:0]   wr_row,
    input  logic [C_DFI_ADDR_WIDTH-2:0]   wr_col,
    output logic [C_DFI_ADDR_WIDTH-1:0]   dfi_address,
    output logic [C_DFI_BANK_WIDTH-1:0]   dfi_bank,
    output logic                          dfi_cs_n,
    output logic                          dfi_ras_n,
    output logic                          dfi_cas_n,
    output logic                          dfi_we_n,
    output logic                          rd_issue,
    output logic                          wr_issue,
    output logic                          ref_busy
);

    localparam int A  = C_DFI_ADDR_WIDTH;
    localparam int B  = C_DFI_BANK_WIDTH;
    localparam int CW = $clog2(C_TRCD + C_TPOST + C_TRFC + 1);
    localparam int TW = $clog2(C_TREFI + 1);
    localparam int SW = $clog2(C_WR_STARVE + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    // Wait counters count down to zero; RCD has one cycle fewer because the
    // CAS state itself supplies the final cycle of the ACT-to-CAS gap.
    localparam logic [CW-1:0] RCD_LOAD  = CW'((C_TRCD > 1) ? C_TRCD - 2 : 0);
    localparam logic [CW-1:0] POST_LOAD = CW'(C_TPOST - 1);
    localparam logic [CW-1:0] RFC_LOAD  = CW'(C_TRFC - 1);
    localparam logic [TW-1:0] REFI_LOAD = TW'(C_TREFI - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(C_WR_STARVE);

    typedef enum logic [2:0] {
        RESET_WAIT,
        IDLE,
        RCD,
        CAS,
        POST,
        REF_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   refi_q;
    logic            ref_pend_q;
    logic [SW-1:0]   starve_q;
    logic [B-1:0]    lat_bank_q;
    logic [A-2:0]    lat_col_q;
    logic            lat_wr_q;
    logic [3:0]      cmd_q, cmd_d;
    logic [A-1:0]    addr_d;
    logic [B-1:0]    bank_d;
    logic            rd_issue_d, wr_issue_d, ref_busy_d;
    logic            ref_issue;
    logic            arb_ok, rd_win, wr_win, refi_expire;

    // Requests are only considered in IDLE with refresh not pending; a write
    // wins when no read is waiting or once reads have starved it long enough.
    assign arb_ok   = (state_q == IDLE) && init_done && !ref_pend_q;
    assign wr_win   = arb_ok && wr_valid && (!rd_valid || (starve_q == STARVE_MAX));
    assign rd_win   = arb_ok && rd_valid && !wr_win;
    assign rd_ready = rd_win;
    assign wr_ready = wr_win;

    assign refi_expire = init_done && (refi_q == '0);

    assign {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = cmd_q;

    // Next state and the next value of every registered DFI output. The
    // address and bank hold their last value through NOP cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = CMD_NOP;
        addr_d     = dfi_address;
        bank_d     = dfi_bank;
        rd_issue_d = 1'b0;
        wr_issue_d = 1'b0;
        ref_busy_d = 1'b0;
        ref_issue  = 1'b0;
        case (state_q)
            RESET_WAIT: begin
                cmd_d = CMD_DESEL;
                if (init_done) state_d = IDLE;
            end
            IDLE: begin
                if (!init_done) begin
                    state_d = RESET_WAIT;
                end else if (ref_pend_q) begin
                    cmd_d      = CMD_REF;
                    addr_d     = '0;
                    ref_issue  = 1'b1;
                    ref_busy_d = 1'b1;
                    cnt_d      = RFC_LOAD;
                    state_d    = REF_WAIT;
                end else if (rd_win || wr_win) begin
                    cmd_d   = CMD_ACT;
                    addr_d  = wr_win ? wr_row : rd_row;
                    bank_d  = wr_win ? wr_bank : rd_bank;
                    cnt_d   = RCD_LOAD;
                    state_d = (C_TRCD > 1) ? RCD : CAS;
                end
            end
            RCD: begin
                if (cnt_q == '0) state_d = CAS;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CAS: begin
                cmd_d      = lat_wr_q ? CMD_WR : CMD_RD;
                addr_d     = {lat_col_q[A-2:10], 1'b1, lat_col_q[9:0]};
                bank_d     = lat_bank_q;
                rd_issue_d = !lat_wr_q;
                wr_issue_d = lat_wr_q;
                cnt_d      = POST_LOAD;
                state_d    = POST;
            end
            POST: begin
                if (cnt_q == '0) state_d = init_done ? IDLE : RESET_WAIT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            REF_WAIT: begin
                ref_busy_d = 1'b1;
                if (cnt_q == '0) state_d = init_done ? IDLE : RESET_WAIT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                cmd_d   = CMD_DESEL;
                state_d = RESET_WAIT;
            end
        endcase
    end

    // FSM state, wait counter and all registered DFI-side outputs.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q     <= RESET_WAIT;
            cnt_q       <= '0;
            cmd_q       <= CMD_DESEL;
            dfi_address <= '0;
            dfi_bank    <= '0;
            rd_issue    <= 1'b0;
            wr_issue    <= 1'b0;
            ref_busy    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            dfi_address <= addr_d;
            dfi_bank    <= bank_d;
            rd_issue    <= rd_issue_d;
            wr_issue    <= wr_issue_d;
            ref_busy    <= ref_busy_d;
        end
    end

    // The granted request's bank, column and direction are held for the CAS
    // command; the row is consumed directly by the ACT.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            lat_bank_q <= '0;
            lat_col_q  <= '0;
            lat_wr_q   <= 1'b0;
        end else if (rd_win || wr_win) begin
            lat_bank_q <= wr_win ? wr_bank : rd_bank;
            lat_col_q  <= wr_win ? wr_col : rd_col;
            lat_wr_q   <= wr_win;
        end
    end

    // Refresh interval timer. An expiry while a refresh is already pending
    // simply re-asserts the flag, so back-to-back expiries collapse into one.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            refi_q     <= REFI_LOAD;
            ref_pend_q <= 1'b0;
        end else begin
            if (init_done) begin
                refi_q <= (refi_q == '0) ? REFI_LOAD : refi_q - TW'(1);
            end
            if (refi_expire)    ref_pend_q <= 1'b1;
            else if (ref_issue) ref_pend_q <= 1'b0;
        end
    end

    // Write starvation counter: reads granted while a write waits push it up
    // to the limit, at which point the next arbitration goes to the write.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            starve_q <= '0;
        end else if (wr_win) begin
            starve_q <= '0;
        end else if (rd_win && wr_valid && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + SW'(1);
        end
    end

endmodule

// File: tb/tb_ddrx_cmd_sched.sv
// tb_ddrx_cmd_sched
// Self-checking bench for ddrx_cmd_sched. Request streams push the expected
// transaction into a scoreboard queue at each handshake; a DFI monitor pops
// and compares on every ACT, checks the RD/WR that follows, and enforces the
// ACT-to-CAS, CAS-to-next and REF-to-next gaps.
module tb_ddrx_cmd_sched;

    localparam int A       = 14;
    localparam int B       = 3;
    localparam int C_TRCD  = 4;
    localparam int C_TPOST = 8;
    localparam int C_TRFC  = 32;
    localparam int C_TREFI = 3120;
    localparam int C_WR_STARVE = 8;

    localparam int K_NONE = 0;
    localparam int K_ACT  = 1;
    localparam int K_CAS  = 2;
    localparam int K_REF  = 3;

    typedef struct {
        bit           is_wr;
        logic [B-1:0] bank;
        logic [A-1:0] row;
        logic [A-2:0] col;
    } req_t;

    logic         core_clk = 1'b0;
    logic         core_arstn = 1'b0;
    logic         init_done = 1'b0;
    logic         rd_valid = 1'b0;
    logic         wr_valid = 1'b0;
    logic [B-1:0] rd_bank = '0;
    logic [A-1:0] rd_row = '0;
    logic [A-2:0] rd_col = '0;
    logic [B-1:0] wr_bank = '0;
    logic [A-1:0] wr_row = '0;
    logic [A-2:0] wr_col = '0;
    logic         rd_ready, wr_ready;
    logic [A-1:0] dfi_address;
    logic [B-1:0] dfi_bank;
    logic         dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic         rd_issue, wr_issue, ref_busy;
    logic [3:0]   dfi_cmd;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   rd_left = 0;
    int   wr_left = 0;
    req_t exp_q[$];
    int   ev_log[$];
    int   act_times[$];
    req_t cur_exp;
    int   last_kind = K_NONE;
    int   last_cyc = 0;
    int   act_cyc = 0;
    int   gap_ref_after_cas = 0;
    int   gap_act_after_ref = 0;
    int   busy_run = 0;
    int   last_busy_run = 0;
    logic [A-1:0] last_cas_addr = '0;

    assign dfi_cmd = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};

    ddrx_cmd_sched #(
        .C_DFI_ADDR_WIDTH(A), .C_DFI_BANK_WIDTH(B), .C_TRCD(C_TRCD),
        .C_TPOST(C_TPOST), .C_TRFC(C_TRFC), .C_TREFI(C_TREFI),
        .C_WR_STARVE(C_WR_STARVE)
    ) dut (
        .core_clk(core_clk), .core_arstn(core_arstn), .init_done(init_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank),
        .rd_row(rd_row), .rd_col(rd_col),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .wr_row(wr_row), .wr_col(wr_col),
        .dfi_address(dfi_address), .dfi_bank(dfi_bank),
        .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
        .dfi_we_n(dfi_we_n), .rd_issue(rd_issue), .wr_issue(wr_issue),
        .ref_busy(ref_busy)
    );

    initial forever #5 core_clk = ~core_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [A-1:0] cas_addr(input logic [A-2:0] col);
        return {col[A-2:10], 1'b1, col[9:0]};
    endfunction

    task automatic tick();
        @(posedge core_clk);
        #2;
    endtask

    task automatic applyStimulus(input int n_rd, input int n_wr);
        rd_left = n_rd;
        wr_left = n_wr;
    endtask

    task automatic monitor_cycle();
        req_t e;
        logic [1:0] iss;
        bit is_wr;
        iss = {rd_issue, wr_issue};
        case (dfi_cmd)
            4'b0011: begin
                if (exp_q.size() == 0) begin
                    checkOutput("act_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    cur_exp = e;
                    checkOutput("act_bank", 32'(dfi_bank), 32'(e.bank));
                    checkOutput("act_row", 32'(dfi_address), 32'(e.row));
                end
                if (last_kind == K_CAS)
                    checkOutput("cas_to_next_gap", 32'((cycle - last_cyc) >= C_TPOST + 1), 1);
                if (last_kind == K_REF) begin
                    gap_act_after_ref = cycle - last_cyc;
                    checkOutput("ref_to_next_gap", 32'(gap_act_after_ref >= C_TRFC + 1), 1);
                end
                checkOutput("act_issue", 32'(iss), 0);
                act_cyc = cycle;
                act_times.push_back(cycle);
                last_kind = K_ACT;
                last_cyc = cycle;
            end
            4'b0101, 4'b0100: begin
                is_wr = (dfi_cmd[0] == 1'b0);
                checkOutput("act_to_cas", 32'(cycle - act_cyc), C_TRCD);
                checkOutput("cas_prev_act", 32'(last_kind), K_ACT);
                checkOutput("cas_dir", 32'(is_wr), 32'(cur_exp.is_wr));
                checkOutput("cas_bank", 32'(dfi_bank), 32'(cur_exp.bank));
                checkOutput("cas_addr", 32'(dfi_address), 32'(cas_addr(cur_exp.col)));
                checkOutput("cas_issue", 32'(iss), is_wr ? 32'd1 : 32'd2);
                last_cas_addr = dfi_address;
                ev_log.push_back(is_wr ? 2 : 1);
                last_kind = K_CAS;
                last_cyc = cycle;
            end
            4'b0001: begin
                checkOutput("ref_addr", 32'(dfi_address), 0);
                checkOutput("ref_busy_at_ref", 32'(ref_busy), 1);
                checkOutput("ref_issue", 32'(iss), 0);
                if (last_kind == K_CAS) begin
                    gap_ref_after_cas = cycle - last_cyc;
                    checkOutput("cas_to_ref_gap", 32'(gap_ref_after_cas >= C_TPOST + 1), 1);
                end
                ev_log.push_back(3);
                last_kind = K_REF;
                last_cyc = cycle;
            end
            4'b0111, 4'b1111: checkOutput("idle_issue", 32'(iss), 0);
            default: checkOutput("illegal_cmd", 32'(dfi_cmd), 32'h7);
        endcase
        if (ref_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    endtask

    // Request streams and DFI monitor. Handshakes are judged at the negedge
    // (ready is stable there) and the next request is presented just after
    // the edge that completed the handshake.
    initial forever begin
        bit rd_hs, wr_hs;
        req_t r;
        @(negedge core_clk);
        cycle++;
        if (!core_arstn) begin
            last_kind = K_NONE;
            busy_run = 0;
        end else begin
            monitor_cycle();
        end
        rd_hs = rd_valid && rd_ready;
        wr_hs = wr_valid && wr_ready;
        if (rd_hs) begin
            r.is_wr = 1'b0; r.bank = rd_bank; r.row = rd_row; r.col = rd_col;
            exp_q.push_back(r);
        end
        if (wr_hs) begin
            r.is_wr = 1'b1; r.bank = wr_bank; r.row = wr_row; r.col = wr_col;
            exp_q.push_back(r);
        end
        @(posedge core_clk);
        #1;
        if (rd_hs) begin
            rd_left--;
            rd_bank = B'($urandom_range(0, 7));
            rd_row  = A'($urandom);
            rd_col  = (A-1)'($urandom);
        end
        if (wr_hs) begin
            wr_left--;
            wr_bank = B'($urandom_range(0, 7));
            wr_row  = A'($urandom);
            wr_col  = (A-1)'($urandom);
        end
        rd_valid = (rd_left > 0);
        wr_valid = (wr_left > 0);
    end

    task automatic clear_logs();
        exp_q.delete();
        ev_log.delete();
        act_times.delete();
    endtask

    task automatic applyReset(input logic init_val);
        core_arstn = 1'b0;
        applyStimulus(0, 0);
        init_done = init_val;
        tick();
        tick();
        clear_logs();
    endtask

    task automatic release_reset();
        tick();
        core_arstn = 1'b1;
    endtask

    task automatic wait_events(input int n, input int budget);
        int k = 0;
        while (ev_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput("wait_events", 32'(ev_log.size() >= n), 1);
    endtask

    task automatic wait_acts(input int n, input int budget);
        int k = 0;
        while (act_times.size() < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput("wait_acts", 32'(act_times.size() >= n), 1);
    endtask

    function automatic logic [31:0] out_vec();
        return {rd_ready, wr_ready, rd_issue, wr_issue, ref_busy,
                dfi_cmd, 3'(dfi_bank), 14'(dfi_address)};
    endfunction

    localparam logic [31:0] RESET_VEC = {5'b0, 4'hF, 3'b0, 14'b0};

    initial begin
        int quiet_bad;
        int lat;
        bit found;

        // Reset state and the first read: bank 2, row 0x155, col 0x1F.
        applyReset(1'b1);
        rd_bank = 3'd2;
        rd_row  = 14'h155;
        rd_col  = 13'h01F;
        applyStimulus(1, 0);
        tick();
        tick();
        checkOutput("reset_outputs", out_vec(), RESET_VEC);
        release_reset();
        wait_events(1, 60);
        checkOutput("first_rd_addr", 32'(last_cas_addr), 32'h41F);
        checkOutput("first_is_read", 32'(ev_log[0]), 1);

        // Both streams held: eight reads then one write, repeating.
        ev_log.delete();
        applyStimulus(18, 2);
        wait_events(20, 20 * 14 + 40);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("grant_%0d", i), 32'(ev_log[i]),
                        (i == 8 || i == 17) ? 32'd2 : 32'd1);
        end

        // Writes only: granted back to back, starvation counter untouched.
        ev_log.delete();
        act_times.delete();
        applyStimulus(0, 3);
        wait_events(3, 80);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("wr_only_%0d", i), 32'(ev_log[i]), 2);
        if (act_times.size() >= 3)
            checkOutput("wr_only_spacing", 32'(act_times[2] - act_times[0]),
                        32'(2 * (C_TRCD + C_TPOST + 1)));
        else
            checkOutput("wr_only_acts", 32'(act_times.size()), 3);
        checkOutput("wr_only_starve", 32'(dut.starve_q), 0);

        // Refresh expiring while a read sits in RCD, with a write waiting.
        applyReset(1'b1);
        release_reset();
        repeat (3116) tick();
        applyStimulus(1, 1);
        wait_events(3, 200);
        checkOutput("ref_order_rd", 32'(ev_log[0]), 1);
        checkOutput("ref_order_ref", 32'(ev_log[1]), 3);
        checkOutput("ref_order_wr", 32'(ev_log[2]), 2);
        checkOutput("ref_after_post", 32'(gap_ref_after_cas), C_TPOST + 1);
        checkOutput("act_after_trfc", 32'(gap_act_after_ref), C_TRFC + 1);
        checkOutput("ref_busy_len", 32'(last_busy_run), C_TRFC + 1);

        // init_done low: DESEL held, no grants, refresh timer frozen.
        applyReset(1'b0);
        release_reset();
        applyStimulus(1, 0);
        quiet_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dfi_cmd != 4'hF || rd_ready || wr_ready) quiet_bad++;
        end
        checkOutput("no_init_quiet", 32'(quiet_bad), 0);
        checkOutput("no_init_timer", 32'(dut.refi_q), 32'(C_TREFI - 1));
        init_done = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            tick();
            if (dfi_cmd == 4'b0011) begin
                found = 1'b1;
                lat = k;
            end
        end
        checkOutput("init_to_act", 32'(found && lat <= 2), 1);
        wait_events(1, 40);

        // Reset asserted inside RCD (phase 0) and inside POST (phase 1).
        for (int phase = 0; phase < 2; phase++) begin
            applyReset(1'b1);
            release_reset();
            applyStimulus(1, 0);
            if (phase == 0) begin
                wait_acts(1, 40);
            end else begin
                wait_events(1, 40);
                tick();
                tick();
            end
            #1;
            core_arstn = 1'b0;
            #1;
            checkOutput($sformatf("mid_reset_outputs_%0d", phase), out_vec(), RESET_VEC);
            tick();
            clear_logs();
            release_reset();
            repeat (30) tick();
            checkOutput($sformatf("no_stale_cas_%0d", phase), 32'(ev_log.size()), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddrx_cmd_sched.md
# ddrx_cmd_sched

Closed-page DDRx command scheduler between the NASTI-side request queues and the DFI control interface of `nasti_ddrx_mc`. It arbitrates between one read and one write request stream and periodically inserts auto-refresh. For each access it issues an ACT/RD or ACT/WR with auto-precharge sequence on the DFI command bus and enforces the configured DRAM timing gaps. Runs entirely in the `core_clk` domain.

## Interface
- `C_DFI_ADDR_WIDTH`, 14, DFI address width; row width equals this, column width is this minus 1.
- `C_DFI_BANK_WIDTH`, 3, DFI bank width.
- `C_TRCD`, 4, ACT-to-CAS cycles (>=1).
- `C_TPOST`, 8, CAS-to-next-command cycles; covers auto-precharge and tRP (>=1).
- `C_TRFC`, 32, REF-to-next-command cycles (>=1).
- `C_TREFI`, 3120, refresh interval in cycles (>= C_TRFC+C_TRCD+C_TPOST+2).
- `C_WR_STARVE`, 8, consecutive read grants after which a waiting write wins.
- `core_clk` in 1: clock, rising edge.
- `core_arstn` in 1: reset; asynchronous assertion, active-low.
- `init_done` in 1: DFI init complete; no commands issue while low.
- `rd_valid`/`rd_ready` in/out 1: read request handshake.
- `rd_bank`, `rd_row`, `rd_col` in B/A/A-1: read target.
- `wr_valid`/`wr_ready` in/out 1: write request handshake.
- `wr_bank`, `wr_row`, `wr_col` in B/A/A-1: write target.
- `dfi_address` out A: DFI command address.
- `dfi_bank` out B: DFI bank.
- `dfi_cs_n`, `dfi_ras_n`, `dfi_cas_n`, `dfi_we_n` out 1 each: DFI command signals.
- `rd_issue`, `wr_issue` out 1: one-cycle pulse, coincident with the RD/WR command on DFI; used by the datapath.
- `ref_busy` out 1: high from the REF command through the end of tRFC.

## Operation
- Command encoding as {cs_n, ras_n, cas_n, we_n}:
  - NOP 0111
  - ACT 0011, address = row
  - RD 0101, address = {col[A-2:10], 1'b1, col[9:0]}; A10 = auto-precharge
  - WR 0100, same address as RD
  - REF 0001, address = 0
  - DESEL 1111
- All DFI outputs are registered.
- FSM states:
  - RESET_WAIT: drive DESEL; go to IDLE when `init_done`=1.
  - IDLE:
    - If `ref_pend`: issue REF, go to REF_WAIT.
    - Otherwise, if a request is granted: issue ACT, latch bank/row/col/dir, go to RCD.
    - Otherwise: issue NOP.
  - RCD: NOP for C_TRCD-1 cycles, then go to CAS.
  - CAS: issue RD or WR and pulse the matching `*_issue`; go to POST.
  - POST: NOP for C_TPOST cycles, then go to IDLE.
  - REF_WAIT: NOP for C_TRFC cycles, then go to IDLE; clear `ref_pend` on REF issue.
- Refresh timer:
  - Free-running down-counter, loaded with C_TREFI-1.
  - Starts once `init_done` is high.
  - At 0 it sets `ref_pend` and reloads.
  - A refresh never preempts an access in progress; it is served at the next IDLE, ahead of any request.
  - If the timer expires again while `ref_pend` is set, the second expiry is lost (no counting).
- Arbitration, evaluated only in IDLE with `init_done`=1 and `ref_pend`=0:
  - Read wins by default.
  - Write wins if `rd_valid`=0, or if `starve_cnt` == C_WR_STARVE.
  - `starve_cnt` increments on each read grant while `wr_valid`=1, saturates at C_WR_STARVE, and clears on a write grant.
- `rd_ready`/`wr_ready` are combinational: high only in the IDLE cycle where that port wins. The ACT issues on the same edge that completes the handshake.
- `init_done` falling mid-sequence: the current sequence completes, then the FSM returns to RESET_WAIT.

## Timing
- Reset values:
  - DFI outputs: DESEL (all 1), `dfi_address`=0, `dfi_bank`=0.
  - `rd_ready`, `wr_ready`, `rd_issue`, `wr_issue`, `ref_busy` = 0.
  - `starve_cnt`=0, `ref_pend`=0, timer=C_TREFI-1, state=RESET_WAIT.
- Handshake at edge T:
  - ACT is visible on DFI at T+1 (output register).
  - RD/WR is visible at T+1+C_TRCD.
  - The next ACT or REF is visible no earlier than T+2+C_TRCD+C_TPOST.
- After REF is visible at cycle R, the next command is visible no earlier than R+1+C_TRFC.
- Valid may be held arbitrarily long; the request is not sampled until ready=1.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronous). In-flight access is dropped.

## Test plan
- Reset release with `init_done`=1 and `rd_valid`, bank 2, row 0x155, col 0x1F:
  - ACT bank 2, address 0x155.
  - 4 cycles later, RD address 0x41F with `rd_issue` pulse.
  - Next command no sooner than 8 NOP cycles later.
- `rd_valid` and `wr_valid` both held continuously with C_WR_STARVE=8:
  - Grant order is 8 reads, 1 write, repeating.
  - `wr_issue` appears exactly every 9th CAS.
- Refresh timer expires during RCD:
  - Access completes.
  - REF follows the POST gap.
  - `ref_busy` high for 33 cycles.
  - Pending request is granted only after that.
- `init_done`=0 after reset: DESEL held, ready stays 0, no refresh counting. Raise `init_done`: first ACT issues next cycle.
- Assert `core_arstn` low during POST: all outputs are at reset values on the same cycle, and no stale RD/WR is issued after release.
- Only `wr_valid`=1: each write is granted as soon as IDLE is reached; `starve_cnt` stays 0.
